// File: rtl/fdtd_hy_sweep_ctrl.sv
// fdtd_hy_sweep_ctrl
//   Sequencer for the pipelined Hy-update datapath (Ez differencing, scale by
//   chyez/chyh, add old Hy). A sweep streams Ez[0..N] and Hy[0..N-1] out of
//   the field SRAMs, drives the datapath clock enable and writes each new Hy
//   back at the pipeline-delayed address. hold freezes everything in place.
//
// Ports
//   CLK, RST    clock, synchronous active-high reset
//   start       single-cycle pulse, accepted only in IDLE
//   n_cells     N, number of Hy cells to update (latched on accepted start)
//   hold        freeze request (no effect in IDLE)
//   ez_rd_en/ez_rd_addr   Ez SRAM read strobe/address (1-cycle latency)
//   hy_rd_en/hy_rd_addr   Hy SRAM read strobe/address (1-cycle latency)
//   calc_clken            datapath clock enable
//   hy_wr_en/hy_wr_addr   Hy SRAM write strobe/address (data from datapath)
//   busy, done            sweep in progress / one-cycle completion pulse
module fdtd_hy_sweep_ctrl #(
    parameter int FDTD_DATA_WIDTH = 32,
    parameter int ADDR_WIDTH      = 10,
    parameter int PIPE_LAT        = 5,
    parameter int HY_RD_DLY       = 3
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] n_cells,
    input  logic                  hold,
    output logic                  ez_rd_en,
    output logic [ADDR_WIDTH-1:0] ez_rd_addr,
    output logic                  hy_rd_en,
    output logic [ADDR_WIDTH-1:0] hy_rd_addr,
    output logic                  calc_clken,
    output logic                  hy_wr_en,
    output logic [ADDR_WIDTH-1:0] hy_wr_addr,
    output logic                  busy,
    output logic                  done
);

    // The data word only flows through the datapath; it is checked here so
    // that a bad instantiation is caught at elaboration.
    if (FDTD_DATA_WIDTH < 1 || ADDR_WIDTH < 1 || PIPE_LAT < 1 ||
        HY_RD_DLY < 1 || HY_RD_DLY > PIPE_LAT) begin : g_param_check
        $error("fdtd_hy_sweep_ctrl: illegal parameter combination");
    end

    localparam int WR_STG = PIPE_LAT + 1;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [ADDR_WIDTH-1:0] n_q, n_d;

    // Tag pipeline: stage k holds the tag of the Ez read issued k clken
    // cycles ago. The stored address is already index-1 (the Hy cell the
    // sample completes), so taps drive the Hy addresses directly.
    logic [WR_STG:1]       tag_vld_q;
    logic [ADDR_WIDTH-1:0] tag_addr_q [1:WR_STG];

    logic                  active;
    logic                  clken;
    logic                  tag_pending;
    logic                  in_vld;
    logic [ADDR_WIDTH-1:0] in_addr;

    always_comb begin
        active      = (state_q == READ) || (state_q == DRAIN);
        clken       = active && !hold;
        // Index 0 only primes the differencer and never produces a write.
        in_vld      = (state_q == READ) && (idx_q != '0);
        in_addr     = in_vld ? (idx_q - 1'b1) : '0;
        // Stages 1..PIPE_LAT; the write stage itself is retiring this cycle.
        tag_pending = |tag_vld_q[PIPE_LAT:1];
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        n_d     = n_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (n_cells != '0) begin
                        n_d     = n_cells;
                        idx_d   = '0;
                        state_d = READ;
                    end else begin
                        state_d = FIN;
                    end
                end
            end
            READ: begin
                if (!hold) begin
                    if (idx_q == n_q) begin
                        state_d = DRAIN;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (!hold && !tag_pending) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                if (!hold) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            n_q       <= '0;
            tag_vld_q <= '0;
            for (int k = 1; k <= WR_STG; k++) begin
                tag_addr_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            n_q     <= n_d;
            // Tags move only with the datapath so they stay aligned under hold.
            if (clken) begin
                tag_vld_q     <= {tag_vld_q[PIPE_LAT:1], in_vld};
                tag_addr_q[1] <= in_addr;
                for (int k = WR_STG; k >= 2; k--) begin
                    tag_addr_q[k] <= tag_addr_q[k-1];
                end
            end
        end
    end

    always_comb begin
        ez_rd_en   = (state_q == READ) && !hold;
        ez_rd_addr = idx_q;
        hy_rd_en   = tag_vld_q[HY_RD_DLY] && clken;
        hy_rd_addr = tag_addr_q[HY_RD_DLY];
        hy_wr_en   = tag_vld_q[WR_STG] && clken;
        hy_wr_addr = tag_addr_q[WR_STG];
        calc_clken = clken;
        busy       = active;
        done       = (state_q == FIN) && !hold;
    end

endmodule

// File: tb/tb_fdtd_hy_sweep_ctrl.sv
module tb_fdtd_hy_sweep_ctrl;

    localparam int AW    = 10;
    localparam int PL    = 5;
    localparam int HYD   = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] n_cells;
    logic          hold;
    logic          ez_rd_en, hy_rd_en, calc_clken, hy_wr_en, busy, done;
    logic [AW-1:0] ez_rd_addr, hy_rd_addr, hy_wr_addr;

    fdtd_hy_sweep_ctrl #(
        .FDTD_DATA_WIDTH(32), .ADDR_WIDTH(AW), .PIPE_LAT(PL), .HY_RD_DLY(HYD)
    ) dut (
        .CLK(clk), .RST(rst), .start(start), .n_cells(n_cells), .hold(hold),
        .ez_rd_en(ez_rd_en), .ez_rd_addr(ez_rd_addr),
        .hy_rd_en(hy_rd_en), .hy_rd_addr(hy_rd_addr),
        .calc_clken(calc_clken),
        .hy_wr_en(hy_wr_en), .hy_wr_addr(hy_wr_addr),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int n;
        int hold_s;
        int hold_l;
        int start2;
        int rst_cyc;
        int exp_done;
        int exp_wr;
        int exp_busy;
    } vec_t;

    typedef struct {
        int cyc;
        int addr;
    } ev_t;

    ev_t  q_ez[$];
    ev_t  q_hr[$];
    ev_t  q_wr[$];
    vec_t tbl[10];
    vec_t cur;
    int   checks = 0;
    int   errors = 0;

    function automatic bit held(input int c);
        return (cur.hold_l > 0) && (c >= cur.hold_s) && (c < cur.hold_s + cur.hold_l);
    endfunction

    // Cycle (relative to the start cycle) of the m-th clken cycle after base.
    function automatic int cyc_of(input int base, input int m);
        int c = base;
        int cnt = 0;
        while (cnt < m) begin
            c++;
            if (!held(c)) cnt++;
        end
        return c;
    endfunction

    task automatic push_run(input int base, input int n, input int lim);
        ev_t e;
        for (int j = 0; j <= n; j++) begin
            e.cyc = cyc_of(base, j + 1); e.addr = j;
            if (lim < 0 || e.cyc <= lim) q_ez.push_back(e);
            if (j >= 1) begin
                e.cyc = cyc_of(base, j + 1 + HYD); e.addr = j - 1;
                if (lim < 0 || e.cyc <= lim) q_hr.push_back(e);
                e.cyc = cyc_of(base, j + 1 + PL + 1); e.addr = j - 1;
                if (lim < 0 || e.cyc <= lim) q_wr.push_back(e);
            end
        end
    endtask

    task automatic pop_check(input int kind, input int c, input int a, input string nm);
        ev_t e;
        bit  empty;
        case (kind)
            0:       empty = (q_ez.size() == 0);
            1:       empty = (q_hr.size() == 0);
            default: empty = (q_wr.size() == 0);
        endcase
        checks++;
        if (empty) begin
            errors++;
            $display("FAIL %s unexpected strobe at cycle %0d addr %0d, none required", nm, c, a);
        end else begin
            case (kind)
                0:       e = q_ez.pop_front();
                1:       e = q_hr.pop_front();
                default: e = q_wr.pop_front();
            endcase
            if (e.cyc != c || e.addr != a) begin
                errors++;
                $display("FAIL %s got cycle %0d addr %0d, required cycle %0d addr %0d",
                         nm, c, a, e.cyc, e.addr);
            end
        end
    endtask

    task automatic check_int(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d required %0d", nm, got, exp);
        end
    endtask

    function automatic logic [3*AW+6-1:0] all_outs();
        return {ez_rd_en, ez_rd_addr, hy_rd_en, hy_rd_addr, calc_clken,
                hy_wr_en, hy_wr_addr, busy, done};
    endfunction

    task automatic run_vec(input int t);
        int done_cnt, done_cyc, wr_cnt, busy_cnt;
        bit second;
        cur = tbl[t];
        q_ez.delete(); q_hr.delete(); q_wr.delete();
        // Reset, then confirm every output is 0.
        rst = 1'b1; start = 1'b0; hold = 1'b0; n_cells = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_int($sformatf("t%0d reset_outputs", t), int'(all_outs() != '0), 0);
        @(posedge clk); #1;
        done_cnt = 0; done_cyc = -1; wr_cnt = 0; busy_cnt = 0;
        second = (cur.rst_cyc >= 0) && (cur.start2 > cur.rst_cyc);
        for (int r = 0; r <= cur.exp_done + 5; r++) begin
            start   = (r == 0) || (r == cur.start2);
            hold    = held(r);
            rst     = (r == cur.rst_cyc);
            n_cells = AW'(cur.n);
            if (r == 0 && cur.n > 0) push_run(0, cur.n, cur.rst_cyc);
            if (second && r == cur.start2) push_run(cur.start2, cur.n, -1);
            @(negedge clk);
            if (ez_rd_en) pop_check(0, r, int'(ez_rd_addr), $sformatf("t%0d ez_rd", t));
            if (hy_rd_en) pop_check(1, r, int'(hy_rd_addr), $sformatf("t%0d hy_rd", t));
            if (hy_wr_en) begin
                wr_cnt++;
                pop_check(2, r, int'(hy_wr_addr), $sformatf("t%0d hy_wr", t));
            end
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = r;
            end
            if (held(r))
                check_int($sformatf("t%0d hold_strobes c%0d", t, r),
                          int'({ez_rd_en, hy_rd_en, hy_wr_en, calc_clken}), 0);
            if (cur.rst_cyc >= 0 && r > cur.rst_cyc && r <= cur.start2)
                check_int($sformatf("t%0d post_reset_outputs c%0d", t, r),
                          int'(all_outs() != '0), 0);
            @(posedge clk); #1;
        end
        start = 1'b0; hold = 1'b0; rst = 1'b0;
        check_int($sformatf("t%0d done_count", t), done_cnt, 1);
        check_int($sformatf("t%0d done_cycle", t), done_cyc, cur.exp_done);
        check_int($sformatf("t%0d write_count", t), wr_cnt, cur.exp_wr);
        check_int($sformatf("t%0d busy_cycles", t), busy_cnt, cur.exp_busy);
        check_int($sformatf("t%0d missing_events", t),
                  q_ez.size() + q_hr.size() + q_wr.size(), 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; hold = 1'b0; n_cells = '0;
        //          n  hs hl  st2 rst  done  wr  busy
        tbl[0] = '{   4,  0, 0,  -1, -1,   12,   4,   11}; // basic sweep
        tbl[1] = '{   0,  0, 0,  -1, -1,    1,   0,    0}; // zero length
        tbl[2] = '{   4,  3, 3,  -1, -1,   15,   4,   14}; // hold mid-stream
        tbl[3] = '{   4,  0, 0,   4, -1,   12,   4,   11}; // start while busy
        tbl[4] = '{   1,  0, 0,  -1, -1,    9,   1,    8}; // single cell
        tbl[5] = '{   4,  0, 1,  -1, -1,   12,   4,   11}; // hold in IDLE
        tbl[6] = '{   2, 10, 2,  -1, -1,   12,   2,    9}; // hold in FIN
        tbl[7] = '{   3,  7, 2,  -1, -1,   13,   3,   12}; // hold in DRAIN
        tbl[8] = '{   4,  0, 0,  12,  9,   24,   6,   20}; // reset mid-op, restart
        tbl[9] = '{1023,  0, 0,  -1, -1, 1031, 1023, 1030}; // max length
        for (int t = 0; t < 10; t++) run_vec(t);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
